// File: rtl/case_7_prod_accum.sv
// Signed product accumulator: sums up to COUNT beats (or until in_last) and emits one registered
// group result on a valid/ready port. Define CASE_7_PROD_ACCUM_SAT_EN for saturating sums with sticky overflow.

module case_7_prod_accum #(
  parameter int PROD_WIDTH = 13,
  parameter int ACC_WIDTH  = 20,
  parameter int COUNT      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_last,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_ovf
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  state_t                      state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]        cnt_r, cnt_nxt_s;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_nxt_s;
  logic                        out_vld_r, out_vld_nxt_s;
  logic signed [ACC_WIDTH-1:0] out_acc_r, out_acc_nxt_s;
  logic [CNT_WIDTH-1:0]        out_cnt_r, out_cnt_nxt_s;
  logic signed [ACC_WIDTH-1:0] base_s, prod_ext_s, sum_s;
  logic                        accept_s, close_s;

`ifdef CASE_7_PROD_ACCUM_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] wide_sum_s;
  logic                      beat_ovf_s;
  logic                      ovf_r, ovf_nxt_s;
  logic                      out_ovf_r, out_ovf_nxt_s;

  // The two top bits of a one-bit-widened sum disagree exactly when it left the ACC_WIDTH range.
  function automatic logic add_ovf(input logic [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
  endfunction
`endif

  assign in_rdy     = (state_r == ST_ACC);
  assign accept_s   = in_vld && in_rdy;
  assign close_s    = (cnt_r == LAST_CNT) || in_last;
  assign base_s     = (cnt_r == {CNT_WIDTH{1'b0}}) ? {ACC_WIDTH{1'b0}} : acc_r;
  assign prod_ext_s = ACC_WIDTH'($signed(in_prod));

`ifdef CASE_7_PROD_ACCUM_SAT_EN
  // Exact sum in ACC_WIDTH+1 bits, clamped toward the side it overflowed on.
  always_comb begin
    sum_s      = {ACC_WIDTH{1'b0}};
    wide_sum_s = {base_s[ACC_WIDTH-1], base_s} + {prod_ext_s[ACC_WIDTH-1], prod_ext_s};
    beat_ovf_s = add_ovf(wide_sum_s);
    if (beat_ovf_s) begin
      sum_s = wide_sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_s = wide_sum_s[ACC_WIDTH-1:0];
    end
  end
`else
  assign sum_s = base_s + prod_ext_s;
`endif

  // Next-state and next-output decode for the ACC/OUT handshake machine.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    acc_nxt_s     = acc_r;
    out_vld_nxt_s = out_vld_r;
    out_acc_nxt_s = out_acc_r;
    out_cnt_nxt_s = out_cnt_r;
`ifdef CASE_7_PROD_ACCUM_SAT_EN
    ovf_nxt_s     = ovf_r;
    out_ovf_nxt_s = out_ovf_r;
`endif
    case (state_r)
      ST_ACC: begin
        if (accept_s) begin
          if (close_s) begin
            out_acc_nxt_s = sum_s;
            out_cnt_nxt_s = cnt_r + CNT_ONE;
            out_vld_nxt_s = 1'b1;
            cnt_nxt_s     = {CNT_WIDTH{1'b0}};
            acc_nxt_s     = {ACC_WIDTH{1'b0}};
            state_nxt_s   = ST_OUT;
`ifdef CASE_7_PROD_ACCUM_SAT_EN
            out_ovf_nxt_s = ovf_r | beat_ovf_s;
            ovf_nxt_s     = 1'b0;
`endif
          end else begin
            acc_nxt_s = sum_s;
            cnt_nxt_s = cnt_r + CNT_ONE;
`ifdef CASE_7_PROD_ACCUM_SAT_EN
            ovf_nxt_s = ovf_r | beat_ovf_s;
`endif
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_OUT: begin
        if (out_vld_r && out_rdy) begin
          out_vld_nxt_s = 1'b0;
          state_nxt_s   = ST_ACC;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s   = ST_ACC;
        out_vld_nxt_s = 1'b0;
      end
    endcase
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r   <= ST_ACC;
      cnt_r     <= {CNT_WIDTH{1'b0}};
      acc_r     <= {ACC_WIDTH{1'b0}};
      out_vld_r <= 1'b0;
      out_acc_r <= {ACC_WIDTH{1'b0}};
      out_cnt_r <= {CNT_WIDTH{1'b0}};
`ifdef CASE_7_PROD_ACCUM_SAT_EN
      ovf_r     <= 1'b0;
      out_ovf_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      acc_r     <= acc_nxt_s;
      out_vld_r <= out_vld_nxt_s;
      out_acc_r <= out_acc_nxt_s;
      out_cnt_r <= out_cnt_nxt_s;
`ifdef CASE_7_PROD_ACCUM_SAT_EN
      ovf_r     <= ovf_nxt_s;
      out_ovf_r <= out_ovf_nxt_s;
`endif
    end
  end

  assign out_vld = out_vld_r;
  assign out_acc = out_acc_r;
  assign out_cnt = out_cnt_r;
`ifdef CASE_7_PROD_ACCUM_SAT_EN
  assign out_ovf = out_ovf_r;
`else
  assign out_ovf = 1'b0;
`endif

  case_7_prod_accum_chk #(
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_chk (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_acc (out_acc),
    .out_cnt (out_cnt)
  );

endmodule

// Protocol properties of the accumulator's two ports.
module case_7_prod_accum_chk #(
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 in_rdy,
  input logic                 out_vld,
  input logic                 out_rdy,
  input logic [ACC_WIDTH-1:0] out_acc,
  input logic [CNT_WIDTH-1:0] out_cnt
);

  a_rdy_excl: assert property (@(posedge clk) disable iff (rst) in_rdy != out_vld);

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_vld && !out_rdy) |=> (out_vld && $stable(out_acc) && $stable(out_cnt)));

  a_cnt_nonzero: assert property (@(posedge clk) disable iff (rst)
    out_vld |-> (out_cnt != {CNT_WIDTH{1'b0}}));

endmodule

// File: tb/tb_case_7_prod_accum.sv
// Scoreboard bench for case_7_prod_accum built with COUNT=4 and ACC_WIDTH=14;
// expectations track CASE_7_PROD_ACCUM_SAT_EN.

module tb_case_7_prod_accum;

  localparam int PW      = 13;
  localparam int AW      = 14;
  localparam int CNT     = 4;
  localparam int CW      = 4;
  localparam int ACC_MAX = (1 << (AW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AW - 1));
  localparam int RANGE   = 1 << AW;

  typedef struct {
    int acc;
    int cnt;
    bit ovf;
  } exp_t;

  logic          ap_clk  = 1'b0;
  logic          ap_rst  = 1'b1;
  logic          in_vld  = 1'b0;
  logic          in_last = 1'b0;
  logic          out_rdy = 1'b1;
  logic [PW-1:0] in_prod = '0;
  logic          in_rdy;
  logic          out_vld;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_cnt;
  logic          out_ovf;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 ap_clk = ~ap_clk;

  case_7_prod_accum #(
    .PROD_WIDTH (PW),
    .ACC_WIDTH  (AW),
    .COUNT      (CNT),
    .CNT_WIDTH  (CW)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_prod (in_prod),
    .in_last (in_last),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_acc (out_acc),
    .out_cnt (out_cnt),
    .out_ovf (out_ovf)
  );

  // Present one beat and hold it until it is accepted; returns at posedge+1.
  task automatic drive_beat(input int prod, input bit last);
    int w = 0;
    in_vld  = 1'b1;
    in_prod = prod[PW-1:0];
    in_last = last;
    @(negedge ap_clk);
    while (!in_rdy && w < 50) begin
      @(negedge ap_clk);
      w++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_rdy=%0b, required 1", in_rdy);
    end
    @(posedge ap_clk);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  // Wait for a result, sample it, and complete the handshake; returns at posedge+1.
  task automatic collect(output int acc, output int cnt, output bit ovf, output bit timed_out);
    int w = 0;
    @(negedge ap_clk);
    while (!out_vld && w < 50) begin
      @(negedge ap_clk);
      w++;
    end
    timed_out = !out_vld;
    acc       = int'($signed(out_acc));
    cnt       = int'(out_cnt);
    ovf       = out_ovf;
    out_rdy   = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checks += 5;
    if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %0b want 0", out_vld); end
    if (out_acc !== '0)   begin errors++; $display("FAIL reset_out_acc got %0d want 0", out_acc); end
    if (out_cnt !== '0)   begin errors++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %0b want 0", out_ovf); end
    if (in_rdy !== 1'b1)  begin errors++; $display("FAIL reset_in_rdy got %0b want 1", in_rdy); end
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  task automatic test_full_group();
    exp_t e;
    sb.push_back('{acc: 49, cnt: 4, ovf: 1'b0});
    drive_beat(100, 1'b0);
    drive_beat(-50, 1'b0);
    drive_beat(4095, 1'b0);
    drive_beat(-4096, 1'b0);
    e = sb.pop_front();
    @(negedge ap_clk);
    checks += 5;
    if (out_vld !== 1'b1) begin errors++; $display("FAIL full_out_vld got %0b want 1", out_vld); end
    if (in_rdy !== 1'b0)  begin errors++; $display("FAIL full_bubble_rdy got %0b want 0", in_rdy); end
    if (int'($signed(out_acc)) != e.acc) begin errors++; $display("FAIL full_acc got %0d want %0d", $signed(out_acc), e.acc); end
    if (int'(out_cnt) != e.cnt) begin errors++; $display("FAIL full_cnt got %0d want %0d", out_cnt, e.cnt); end
    if (out_ovf !== e.ovf) begin errors++; $display("FAIL full_ovf got %0b want %0b", out_ovf, e.ovf); end
    @(negedge ap_clk);
    checks += 2;
    if (in_rdy !== 1'b1)  begin errors++; $display("FAIL full_rdy_back got %0b want 1", in_rdy); end
    if (out_vld !== 1'b0) begin errors++; $display("FAIL full_vld_drop got %0b want 0", out_vld); end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_early_last();
    exp_t e;
    int acc, cnt;
    bit ovf, to;
    sb.push_back('{acc: 4, cnt: 2, ovf: 1'b0});
    drive_beat(7, 1'b0);
    drive_beat(-3, 1'b1);
    sb.push_back('{acc: 5, cnt: 1, ovf: 1'b0});
    for (int g = 0; g < 2; g++) begin
      if (g == 1) drive_beat(5, 1'b1);
      collect(acc, cnt, ovf, to);
      e = sb.pop_front();
      checks += 4;
      if (to)          begin errors++; $display("FAIL early_timeout group %0d", g); end
      if (acc != e.acc) begin errors++; $display("FAIL early_acc group %0d got %0d want %0d", g, acc, e.acc); end
      if (cnt != e.cnt) begin errors++; $display("FAIL early_cnt group %0d got %0d want %0d", g, cnt, e.cnt); end
      if (ovf != e.ovf) begin errors++; $display("FAIL early_ovf group %0d got %0b want %0b", g, ovf, e.ovf); end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int acc, cnt;
    bit ovf, to;
`ifdef CASE_7_PROD_ACCUM_SAT_EN
    sb.push_back('{acc: 8191, cnt: 4, ovf: 1'b1});
    sb.push_back('{acc: -8192, cnt: 4, ovf: 1'b1});
`else
    sb.push_back('{acc: -4, cnt: 4, ovf: 1'b0});
    sb.push_back('{acc: 0, cnt: 4, ovf: 1'b0});
`endif
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < 4; b++) drive_beat((g == 0) ? 4095 : -4096, 1'b0);
      collect(acc, cnt, ovf, to);
      e = sb.pop_front();
      checks += 4;
      if (to)           begin errors++; $display("FAIL ovf_timeout group %0d", g); end
      if (acc != e.acc) begin errors++; $display("FAIL ovf_acc group %0d got %0d want %0d", g, acc, e.acc); end
      if (cnt != e.cnt) begin errors++; $display("FAIL ovf_cnt group %0d got %0d want %0d", g, cnt, e.cnt); end
      if (ovf != e.ovf) begin errors++; $display("FAIL ovf_flag group %0d got %0b want %0b", g, ovf, e.ovf); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int acc, cnt;
    bit ovf, to;
    out_rdy = 1'b0;
    sb.push_back('{acc: 60, cnt: 3, ovf: 1'b0});
    drive_beat(10, 1'b0);
    drive_beat(20, 1'b0);
    drive_beat(30, 1'b1);
    e = sb.pop_front();
    in_vld  = 1'b1;
    in_prod = 13'd99;
    in_last = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      checks += 4;
      if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_vld cycle %0d got %0b want 1", c, out_vld); end
      if (in_rdy !== 1'b0)  begin errors++; $display("FAIL bp_rdy cycle %0d got %0b want 0", c, in_rdy); end
      if (int'($signed(out_acc)) != e.acc) begin errors++; $display("FAIL bp_acc cycle %0d got %0d want %0d", c, $signed(out_acc), e.acc); end
      if (int'(out_cnt) != e.cnt) begin errors++; $display("FAIL bp_cnt cycle %0d got %0d want %0d", c, out_cnt, e.cnt); end
    end
    out_rdy = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %0b want 1", in_rdy); end
    @(posedge ap_clk);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    sb.push_back('{acc: 99, cnt: 1, ovf: 1'b0});
    collect(acc, cnt, ovf, to);
    e = sb.pop_front();
    checks += 3;
    if (to)           begin errors++; $display("FAIL bp_pending_timeout"); end
    if (acc != e.acc) begin errors++; $display("FAIL bp_pending_acc got %0d want %0d", acc, e.acc); end
    if (cnt != e.cnt) begin errors++; $display("FAIL bp_pending_cnt got %0d want %0d", cnt, e.cnt); end
  endtask

  task automatic test_reset_mid_group();
    exp_t e;
    int acc, cnt;
    bit ovf, to;
    for (int b = 0; b < 3; b++) drive_beat(1000, 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checks += 4;
    if (out_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld got %0b want 0", out_vld); end
    if (out_acc !== '0)   begin errors++; $display("FAIL midrst_acc got %0d want 0", out_acc); end
    if (out_cnt !== '0)   begin errors++; $display("FAIL midrst_cnt got %0d want 0", out_cnt); end
    if (in_rdy !== 1'b1)  begin errors++; $display("FAIL midrst_rdy got %0b want 1", in_rdy); end
    @(posedge ap_clk);
    #1;
    sb.push_back('{acc: 4, cnt: 4, ovf: 1'b0});
    for (int b = 0; b < 4; b++) drive_beat(1, 1'b0);
    collect(acc, cnt, ovf, to);
    e = sb.pop_front();
    checks += 3;
    if (to)           begin errors++; $display("FAIL midrst_timeout"); end
    if (acc != e.acc) begin errors++; $display("FAIL midrst_group_acc got %0d want %0d", acc, e.acc); end
    if (cnt != e.cnt) begin errors++; $display("FAIL midrst_group_cnt got %0d want %0d", cnt, e.cnt); end
  endtask

  task automatic test_random();
    exp_t   e;
    int     beats = 0;
    int     cyc = 0;
    int     m_cnt = 0;
    int     m_acc = 0;
    bit     m_ovf = 1'b0;
    bit     m_out = 1'b0;
    bit     m_out_n;
    int     p, s;
    longint t;
    while ((beats < 10000 || m_out) && cyc < 80000) begin
      in_vld  = (beats < 10000) && ($urandom_range(3) != 0);
      in_prod = PW'($urandom);
      in_last = ($urandom_range(4) == 0);
      out_rdy = ($urandom_range(3) != 0);
      @(negedge ap_clk);
      m_out_n = m_out;
      checks += 2;
      if (out_vld !== m_out) begin errors++; $display("FAIL rand_vld cycle %0d got %0b want %0b", cyc, out_vld, m_out); end
      if (in_rdy !== !m_out) begin errors++; $display("FAIL rand_rdy cycle %0d got %0b want %0b", cyc, in_rdy, !m_out); end
      if (m_out && out_rdy) begin
        m_out_n = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_no_expected cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          checks += 3;
          if (int'($signed(out_acc)) != e.acc) begin errors++; $display("FAIL rand_acc cycle %0d got %0d want %0d", cyc, $signed(out_acc), e.acc); end
          if (int'(out_cnt) != e.cnt) begin errors++; $display("FAIL rand_cnt cycle %0d got %0d want %0d", cyc, out_cnt, e.cnt); end
          if (out_ovf !== e.ovf) begin errors++; $display("FAIL rand_ovf cycle %0d got %0b want %0b", cyc, out_ovf, e.ovf); end
        end
      end
      if (in_vld && !m_out) begin
        beats++;
        p = int'($signed(in_prod));
        t = longint'((m_cnt == 0) ? 0 : m_acc) + longint'(p);
`ifdef CASE_7_PROD_ACCUM_SAT_EN
        if (t > ACC_MAX) begin
          s = ACC_MAX;
          m_ovf = 1'b1;
        end else if (t < ACC_MIN) begin
          s = ACC_MIN;
          m_ovf = 1'b1;
        end else begin
          s = int'(t);
        end
`else
        s = int'(((t - ACC_MIN) % RANGE + RANGE) % RANGE + ACC_MIN);
`endif
        if (in_last || m_cnt == CNT - 1) begin
          sb.push_back('{acc: s, cnt: m_cnt + 1, ovf: m_ovf});
          m_cnt   = 0;
          m_acc   = 0;
          m_ovf   = 1'b0;
          m_out_n = 1'b1;
        end else begin
          m_acc = s;
          m_cnt++;
        end
      end
      @(posedge ap_clk);
      #1;
      m_out = m_out_n;
      cyc++;
    end
    in_vld = 1'b0;
    checks += 2;
    if (cyc >= 80000)   begin errors++; $display("FAIL rand_timeout beats=%0d want 10000", beats); end
    if (sb.size() != 0) begin errors++; $display("FAIL rand_lost_results pending=%0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_early_last();
    test_overflow();
    test_backpressure();
    test_reset_mid_group();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/case_7_prod_accum.md
Name: case_7_prod_accum

Overview:
- Downstream consumer of the 13-bit signed truncated product from the case_7 multiplier stage (din0 13s × din1 7s → dout 13s).
- Accumulates signed products over a group of up to COUNT beats, or fewer when terminated by in_last, then presents one registered sum on a valid/ready output.
- Sits between the combinational multiplier and the case_7 result writer; adds the pipeline register that the multiplier itself lacks.

Parameters:
- PROD_WIDTH, 13, width of the signed product input; matches the multiplier dout width.
- ACC_WIDTH, 20, width of the signed accumulator and output. Must be ≥ PROD_WIDTH.
- COUNT, 8, maximum beats per group; must be ≥ 2.
- CNT_WIDTH, 4, width of the beat counter and out_cnt; must hold the value COUNT.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- in_vld  in  1  product beat valid.
- in_rdy  out  1  block accepts a beat this cycle.
- in_prod  in  PROD_WIDTH  signed product (two's complement).
- in_last  in  1  beat closes the current group early; sampled only on accept.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts the result.
- out_acc  out  ACC_WIDTH  signed group sum.
- out_cnt  out  CNT_WIDTH  number of beats in the group, 1..COUNT.
- out_ovf  out  1  group overflowed (see Optional Feature).

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - state=ACC, cnt=0, acc=0, ovf=0.
  - out_vld=0, out_acc=0, out_cnt=0, out_ovf=0.
  - Reset takes priority over all other activity; a partial group is discarded with no output.
- State ACC:
  - in_rdy=1 and out_vld=0.
  - Accept condition: in_vld && in_rdy.
  - Sum term: sum = base + sext(in_prod) to ACC_WIDTH, where base=0 if cnt==0, else base=acc. There is no separate clear cycle.
- Group close: on an accept with (cnt==COUNT-1) || in_last:
  - out_acc <= sum (after the overflow rule), out_cnt <= cnt+1, out_ovf <= ovf | this beat's overflow.
  - out_vld <= 1, cnt <= 0, acc <= 0, ovf <= 0, state <= OUT.
- Accept without close: acc <= sum, cnt <= cnt+1, ovf <= ovf | this beat's overflow.
- State OUT:
  - in_rdy=0; the input is back-pressured.
  - out_acc, out_cnt and out_ovf are held stable while out_vld=1 && out_rdy=0.
  - On out_vld && out_rdy: out_vld <= 0, state <= ACC. out_acc, out_cnt and out_ovf keep their last values.
- Latency: closing beat accepted at edge t → out_vld=1 after edge t. Earliest next accept is after edge t+1, giving one bubble per group.
- in_rdy is a decode of state only; it never depends on in_vld.
- in_prod and in_last are ignored when no accept occurs.
- A single-beat group (in_last on the first beat) gives out_acc=sext(in_prod) and out_cnt=1.
- in_last on a beat with cnt==COUNT-1 closes the group once, identical to close without in_last.
- Arithmetic: all values are signed two's complement. Overflow on a beat means the true sum of base + sext(in_prod) lies outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].

Optional Feature:
- Macro: CASE_7_PROD_ACCUM_SAT_EN.
- Defined:
  - On an overflowing beat, sum clamps to 2^(ACC_WIDTH-1)-1 (positive overflow) or -2^(ACC_WIDTH-1) (negative overflow).
  - ovf sets and is sticky within the group.
  - Later beats accumulate from the clamped value.
- Undefined:
  - sum wraps modulo 2^ACC_WIDTH.
  - ovf and out_ovf are constant 0; no saturation logic is synthesized.

Test Plan:
- Full group, defaults with COUNT=4: beats 100, -50, 4095, -4096 with out_rdy=1 → one cycle after the 4th accept, out_vld=1, out_acc=49, out_cnt=4, out_ovf=0. in_rdy=0 for exactly 1 cycle.
- Early termination: beats 7 then -3 with in_last=1 on the second → out_acc=4, out_cnt=2. A following beat 5 with in_last=1 → out_acc=5, out_cnt=1 (no residue from the prior group).
- Overflow with ACC_WIDTH=14 and COUNT=4: four beats of 4095.
  - With the macro: out_acc=8191, out_ovf=1.
  - Without the macro: out_acc=-4, out_ovf=0.
  - Repeat with four beats of -4096: with the macro -8192/ovf=1; without the macro 0.
- Backpressure: hold out_rdy=0 for 5 cycles after out_vld rises → out_acc and out_cnt stable, in_rdy=0 throughout, in_vld=1 beats not consumed. Release out_rdy → the next group starts with the pending beat on the following cycle.
- Reset mid-group: accept 3 beats of 1000, assert ap_rst for 1 cycle → all outputs 0. A new 4-beat group of 1s yields out_acc=4, out_cnt=4.
- Random stress: random in_vld/out_rdy/in_last over 10k beats against a scoreboard model → every sum and count matches, and there are no lost or duplicated results.
